// File: rtl/uart_rx_deframe.sv
// UART frame checker and show-ahead byte FIFO: validates start/stop/parity of
// each captured 11-bit frame on the rising edge of recieved_flag and queues good bytes.
module uart_rx_deframe #(
    parameter int FIFO_AW    = 2,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic               baud_clk,
    input  logic               reset_n,
    input  logic               recieved_flag,
    input  logic [10:0]        data_parll,
    input  logic               rd_en,
    output logic [7:0]         data_out,
    output logic               data_valid,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               full,
    output logic               frame_err,
    output logic               parity_err,
    output logic               overflow
);

    localparam int                 DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               flag_q;
    logic               frame_err_q, frame_err_d;
    logic               parity_err_q, parity_err_d;
    logic               overflow_q, overflow_d;

    logic new_frame, frame_ok, parity_ok, push_req, push, pop;

    assign new_frame = recieved_flag & ~flag_q;
    assign frame_ok  = ~data_parll[0] & data_parll[10];
    assign parity_ok = ((^data_parll[9:1]) == PARITY_ODD);
    assign push_req  = new_frame & frame_ok & parity_ok;
    assign pop       = rd_en & (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push      = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        frame_err_d  = new_frame & ~frame_ok;
        parity_err_d = new_frame & frame_ok & ~parity_ok;
        overflow_d   = push_req & ~push;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // flag_q resets high so a flag already asserted at reset release is ignored
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q       <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            flag_q       <= recieved_flag;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_parll[8:1];
        end
    end

    assign data_valid = (count_q != '0);
    assign data_out   = data_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign full       = (count_q == CNT_FULL);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Directed bench for uart_rx_deframe with default parameters (depth 4, even parity).
module tb_uart_rx_deframe;

    logic        baud_clk = 1'b0;
    logic        reset_n;
    logic        recieved_flag;
    logic [10:0] data_parll;
    logic        rd_en;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [2:0]  fifo_count;
    logic        full;
    logic        frame_err;
    logic        parity_err;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    uart_rx_deframe dut (
        .baud_clk     (baud_clk),
        .reset_n      (reset_n),
        .recieved_flag(recieved_flag),
        .data_parll   (data_parll),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .fifo_count   (fifo_count),
        .full         (full),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .overflow     (overflow)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    // even-parity frame: stop=1, parity, data, start=0
    function automatic logic [10:0] mk(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic frame_edge(input logic [10:0] f, input logic rd);
        recieved_flag = 1'b1;
        data_parll    = f;
        rd_en         = rd;
        tick();
    endtask

    task automatic idle();
        recieved_flag = 1'b0;
        rd_en         = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        recieved_flag = 1'b1;
        data_parll    = 11'h54A;
        rd_en         = 1'b0;
        tick();
        tick();
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_full", full, 0);
        chk("rst_errs", {frame_err, parity_err, overflow}, 0);

        // flag already high at release must not count as a frame
        reset_n = 1'b1;
        tick();
        tick();
        chk("flag_high_release", fifo_count, 0);
        idle();

        // good frame, flag held 3 cycles
        frame_edge(11'h54A, 1'b0);
        chk("good_dout", data_out, 8'hA5);
        chk("good_valid", data_valid, 1);
        chk("good_count", fifo_count, 1);
        tick();
        tick();
        chk("good_single_push", fifo_count, 1);
        idle();
        pop_one();
        chk("pop_count", fifo_count, 0);
        chk("pop_dout_zero", data_out, 8'h00);
        pop_one();
        chk("pop_empty_count", fifo_count, 0);
        chk("pop_empty_errs", {frame_err, parity_err, overflow}, 0);

        frame_edge(11'h74A, 1'b0);
        chk("par_err", parity_err, 1);
        chk("par_no_ferr", frame_err, 0);
        chk("par_count", fifo_count, 0);
        idle();
        chk("par_pulse_end", parity_err, 0);

        frame_edge(11'h14A, 1'b0);
        chk("stop_ferr", frame_err, 1);
        chk("stop_no_perr", parity_err, 0);
        chk("stop_count", fifo_count, 0);
        idle();
        chk("stop_pulse_end", frame_err, 0);

        frame_edge(11'h54B, 1'b0);
        chk("start_ferr", frame_err, 1);
        chk("start_count", fifo_count, 0);
        idle();

        // overflow on 5th frame
        for (int i = 1; i <= 5; i++) begin
            frame_edge(mk(8'(i)), 1'b0);
            chk("ovf_pulse", overflow, (i == 5) ? 1 : 0);
            idle();
        end
        chk("ovf_full", full, 1);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_pulse_end", overflow, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_data", data_out, i);
            pop_one();
        end
        chk("ovf_drained", fifo_count, 0);

        // push while full with pop
        for (int i = 0; i < 4; i++) begin
            frame_edge(mk(8'h10 + 8'(i)), 1'b0);
            idle();
        end
        frame_edge(mk(8'h20), 1'b1);
        chk("full_rd_ovf", overflow, 0);
        chk("full_rd_count", fifo_count, 4);
        chk("full_rd_dout", data_out, 8'h11);
        idle();
        chk("full_rd_ovf2", overflow, 0);
        chk("full_rd_d1", data_out, 8'h11); pop_one();
        chk("full_rd_d2", data_out, 8'h12); pop_one();
        chk("full_rd_d3", data_out, 8'h13); pop_one();
        chk("full_rd_d4", data_out, 8'h20); pop_one();
        chk("full_rd_empty", fifo_count, 0);

        // push while empty with pop
        frame_edge(mk(8'h33), 1'b1);
        chk("empty_rd_count", fifo_count, 1);
        chk("empty_rd_dout", data_out, 8'h33);
        idle();
        pop_one();

        // push+pop while non-empty
        frame_edge(mk(8'h40), 1'b0);
        idle();
        frame_edge(mk(8'h41), 1'b1);
        chk("pp_count", fifo_count, 1);
        chk("pp_dout", data_out, 8'h41);
        idle();
        pop_one();

        // reset mid-operation with stored bytes and a pending error pulse
        for (int i = 0; i < 3; i++) begin
            frame_edge(mk(8'h50 + 8'(i)), 1'b0);
            idle();
        end
        chk("pre_rst_count", fifo_count, 3);
        frame_edge(11'h74A, 1'b0);
        chk("pre_rst_perr", parity_err, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_valid", data_valid, 0);
        chk("mid_rst_dout", data_out, 8'h00);
        chk("mid_rst_errs", {full, frame_err, parity_err, overflow}, 0);
        data_parll = mk(8'h60);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_no_push", fifo_count, 0);
        idle();
        frame_edge(mk(8'h60), 1'b0);
        chk("post_rst_push", fifo_count, 1);
        chk("post_rst_dout", data_out, 8'h60);
        idle();
        pop_one();

        // wrap: 10 bytes, at most 2 outstanding
        frame_edge(mk(8'h70), 1'b0);
        idle();
        frame_edge(mk(8'h71), 1'b0);
        idle();
        for (int i = 2; i < 10; i++) begin
            chk("wrap_head", data_out, 8'h70 + i - 2);
            frame_edge(mk(8'h70 + 8'(i)), 1'b1);
            chk("wrap_count", fifo_count, 2);
            idle();
        end
        chk("wrap_tail1", data_out, 8'h78); pop_one();
        chk("wrap_tail2", data_out, 8'h79); pop_one();
        chk("wrap_empty", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframe.md
UART_RX_DEFRAME -- requirements
Module: uart_rx_deframe

Interface
REQ-001 The block SHALL have a parameter FIFO_AW, default 2, giving the FIFO address width; depth = 2^FIFO_AW entries.
REQ-002 The block SHALL have a parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 baud_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 recieved_flag  input  1  frame-ready level from the upstream SIPO; its rising edge marks a new frame.
REQ-006 data_parll  input  11  captured frame; bit0 start, bits8:1 data LSB-first (data[0]=bit1), bit9 parity, bit10 stop.
REQ-007 rd_en  input  1  consumer pop request.
REQ-008 data_out  output  8  FIFO head byte (show-ahead).
REQ-009 data_valid  output  1  high when FIFO is non-empty.
REQ-010 fifo_count  output  FIFO_AW+1  number of stored bytes.
REQ-011 full  output  1  high when fifo_count = 2^FIFO_AW.
REQ-012 frame_err  output  1  one-cycle pulse: frame rejected for a bad start or stop bit.
REQ-013 parity_err  output  1  one-cycle pulse: frame rejected for a parity mismatch.
REQ-014 overflow  output  1  one-cycle pulse: good frame dropped because the FIFO was full.

Function
REQ-015 The block SHALL register recieved_flag as flag_d and detect a new frame at an edge where recieved_flag=1 and flag_d=0; holding the flag high for several cycles SHALL yield exactly one detection.
REQ-016 On detection, the frame SHALL be checked against data_parll sampled at that same edge.
REQ-017 Frame check rules:
- frame_ok = (bit0==0) && (bit10==1).
- parity_ok = (^bits9:1) == PARITY_ODD.
REQ-018 If frame_ok is false, the block SHALL assert frame_err for 1 cycle and SHALL NOT push; parity_err SHALL stay 0 for that frame (framing errors take priority).
REQ-019 If frame_ok is true and parity_ok is false, the block SHALL assert parity_err for 1 cycle and SHALL NOT push.
REQ-020 If both checks pass, the block SHALL push bits8:1 into the FIFO at the detection edge; data_valid and fifo_count SHALL reflect the push on the cycle after that edge (latency 1 cycle).
REQ-021 Pop: at an edge with rd_en=1 and fifo_count>0, the block SHALL advance the read pointer; data_out SHALL show the next entry on the following cycle.
REQ-022 Pop when empty: rd_en SHALL be ignored, with no pointer change and no error.
REQ-023 Simultaneous push and pop, FIFO not empty: both occur, fifo_count is unchanged, and data_out advances to the next entry.
REQ-024 Simultaneous push and pop, FIFO empty: only the push occurs and fifo_count becomes 1.
REQ-025 Simultaneous push and pop, FIFO full: both occur, no overflow, and fifo_count is unchanged.
REQ-026 Push attempt with the FIFO full and no pop: the byte is dropped, overflow pulses for 1 cycle, and the FIFO contents are unchanged.
REQ-027 Read and write pointers SHALL be FIFO_AW bits wide and wrap modulo 2^FIFO_AW; fifo_count SHALL saturate at neither end, as REQ-022 and REQ-026 prevent over- and under-run.
REQ-028 When data_valid=0, data_out SHALL be 8'h00.

Reset
REQ-029 While reset_n=0, the following SHALL hold asynchronously:
- pointers and fifo_count are 0;
- data_valid, full, frame_err, parity_err and overflow are 0;
- data_out is 8'h00.
REQ-030 flag_d SHALL reset to 1, so a recieved_flag already high at reset release SHALL NOT be taken as a new frame.
REQ-031 A reset asserted mid-operation SHALL discard all stored bytes and any pending error pulse.
REQ-032 FIFO storage contents need not be reset.

Verification
REQ-033 Good frame: PARITY_ODD=0, data_parll=11'h54A, recieved_flag held high for 3 cycles -> data_out=8'hA5, data_valid=1 and fifo_count=1 one cycle after the rise; only one push occurs.
REQ-034 Error frames, each presented via a single rise:
- 11'h74A -> parity_err pulse, fifo_count stays 0.
- 11'h14A -> frame_err pulse, no parity_err.
- 11'h54B -> frame_err pulse.
REQ-035 Overflow: push 5 good frames (bytes 01,02,03,04,05 with correct parity) at FIFO_AW=2 and no reads -> full=1, fifo_count=4, overflow pulses on the 5th frame, and pops return 01,02,03,04.
REQ-036 Simultaneous events:
- Good frame arrives while full with rd_en=1 -> no overflow, fifo_count stays 4.
- Good frame arrives while empty with rd_en=1 -> fifo_count becomes 1.
REQ-037 Reset: assert reset_n=0 with 3 bytes stored and recieved_flag=1 -> all outputs reset at once; on release with recieved_flag still 1 -> no push until the flag falls and rises again.
REQ-038 Wrap: push and pop 10 sequential bytes with at most 2 outstanding -> pop order matches push order across pointer wrap.
